// File: rtl/frame_bank_if.sv
// Handshake and address bus between the bank scheduler, the frame writer and the vector display.
// master = scheduler side, slave = writer/display side.
interface frame_bank_if #(
   parameter int ADDRESSWIDTH = 16,
   parameter int CNT_WIDTH    = 16
);
   logic                    build_start;
   logic                    build_done;
   logic [ADDRESSWIDTH-1:0] wr_adr_local;
   logic                    wr_en_local;
   logic [ADDRESSWIDTH-1:0] wr_adr;
   logic                    wr_en;
   logic [ADDRESSWIDTH-1:0] rd_adr_local;
   logic [ADDRESSWIDTH-1:0] rd_adr;
   logic                    go;
   logic                    halt;
   logic                    front_bank;
   logic [CNT_WIDTH-1:0]    frame_cnt;
   logic [CNT_WIDTH-1:0]    replay_cnt;
   logic                    ovf_err;
   logic                    wd_err;

   modport master (
      input  build_done, wr_adr_local, wr_en_local, rd_adr_local, halt,
      output build_start, wr_adr, wr_en, rd_adr, go, front_bank,
             frame_cnt, replay_cnt, ovf_err, wd_err
   );

   modport slave (
      output build_done, wr_adr_local, wr_en_local, rd_adr_local, halt,
      input  build_start, wr_adr, wr_en, rd_adr, go, front_bank,
             frame_cnt, replay_cnt, ovf_err, wd_err
   );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ping-pong front/back bank scheduler: builds into the back bank, swaps on completion, replays stale frames.
// Latency: build_done -> bank swap +1 cycle -> go +2 cycles; display backpressure holds a finished build in S_READY.
module frame_bank_scheduler #(
   parameter int ADDRESSWIDTH = 16,
   parameter int BANK_DEPTH   = 500,
   parameter int WD_CYCLES    = 400000,
   parameter int CNT_WIDTH    = 16
) (
   input logic          clk,
   input logic          rst,
   frame_bank_if.master bus
);
   localparam int WD_W = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
   localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(WD_CYCLES - 1);
   localparam logic [ADDRESSWIDTH-1:0] BANK_OFS = ADDRESSWIDTH'(BANK_DEPTH);

   typedef enum logic [1:0] {S_KICK, S_BUILD, S_READY} state_t;

   state_t               state;
   logic                 front_bank;
   logic                 go;
   logic                 go_pend;
   logic                 build_start;
   logic                 disp_busy;
   logic                 halt_pend;
   logic                 ovf_err;
   logic                 wd_err;
   logic [CNT_WIDTH-1:0] frame_cnt;
   logic [CNT_WIDTH-1:0] replay_cnt;
   logic [WD_W-1:0]      wd_cnt;

   logic wd_fire;
   logic eff_halt;
   logic in_range;
   logic replay;
   logic swap;

   // A watchdog expiry stands in for a halt; halts while the display is idle are meaningless.
   always_comb begin
      wd_fire  = disp_busy && (wd_cnt == WD_LAST);
      eff_halt = disp_busy && (bus.halt || wd_fire);
      in_range = bus.wr_adr_local < BANK_OFS;
      replay   = (state == S_BUILD) && !bus.build_done && eff_halt;
      swap     = (state == S_READY) && (!disp_busy || eff_halt || halt_pend);
   end

   assign bus.wr_adr      = (front_bank ? '0 : BANK_OFS) + bus.wr_adr_local;
   assign bus.rd_adr      = (front_bank ? BANK_OFS : '0) + bus.rd_adr_local;
   assign bus.wr_en       = bus.wr_en_local && (state == S_BUILD) && in_range;
   assign bus.build_start = build_start;
   assign bus.go          = go;
   assign bus.front_bank  = front_bank;
   assign bus.frame_cnt   = frame_cnt;
   assign bus.replay_cnt  = replay_cnt;
   assign bus.ovf_err     = ovf_err;
   assign bus.wd_err      = wd_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_KICK;
         front_bank  <= 1'b0;
         go          <= 1'b0;
         go_pend     <= 1'b0;
         build_start <= 1'b0;
         disp_busy   <= 1'b0;
         halt_pend   <= 1'b0;
         ovf_err     <= 1'b0;
         wd_err      <= 1'b0;
         frame_cnt   <= '0;
         replay_cnt  <= '0;
         wd_cnt      <= '0;
      end else begin
         build_start <= 1'b0;
         go          <= go_pend;
         go_pend     <= 1'b0;

         case (state)
            S_KICK: begin
               build_start <= 1'b1;
               state       <= S_BUILD;
            end
            S_BUILD: begin
               if (bus.build_done) begin
                  state <= S_READY;
                  // Halt coinciding with completion: swap instead of replaying the old frame.
                  if (eff_halt) halt_pend <= 1'b1;
               end else if (eff_halt) begin
                  replay_cnt <= replay_cnt + 1'b1;
                  go_pend    <= 1'b1;
               end
            end
            S_READY: begin
               if (swap) begin
                  front_bank <= ~front_bank;
                  frame_cnt  <= frame_cnt + 1'b1;
                  go_pend    <= 1'b1;
                  halt_pend  <= 1'b0;
                  state      <= S_KICK;
               end
            end
            default: state <= S_KICK;
         endcase

         if (replay || swap)   disp_busy <= 1'b1;
         else if (eff_halt)    disp_busy <= 1'b0;

         if (replay || swap || !disp_busy || wd_fire) wd_cnt <= '0;
         else                                         wd_cnt <= wd_cnt + 1'b1;

         if (wd_fire)                          wd_err  <= 1'b1;
         if (bus.wr_en_local && !in_range)     ovf_err <= 1'b1;
      end
   end
endmodule
